// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer for the 5-stage RISC-V core: drives stall/flush/enable
// controls for the PC and pipeline registers, plus stall/flush statistics and a memory timeout flag.
module hazard_sequencer #(
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_hasRs1,
    input  logic             id_hasRs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_hasRd,
    input  logic             ex_memRead,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       WAIT_MAX = 8'(MAX_WAIT);
    localparam logic [1:0]       BUB_INIT = 2'(LOAD_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_bub;
    logic [1:0]       w_bub_nxt;
    logic [7:0]       r_wait;
    logic [7:0]       w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_timeout;

    logic w_lu;
    logic w_mw;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_ifid_flush;
    logic w_idex_en;
    logic w_idex_flush;
    logic w_exmem_en;
    logic w_memwb_flush;
    logic w_flush_evt;
    logic w_timeout_set;

    // x0 is hardwired zero, so a load targeting it can never create a hazard.
    assign w_lu = ex_memRead & ex_hasRd & (ex_rd != 5'd0) &
                  ((id_hasRs1 & (id_rs1 == ex_rd)) | (id_hasRs2 & (id_rs2 == ex_rd)));
    assign w_mw = mem_access & ~dmem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_bub   <= 2'd0;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Priority: memory freeze, then branch squash, then load-use bubbles.
    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_en     = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_en    = 1'b1;
        w_memwb_flush = 1'b0;
        w_flush_evt   = 1'b0;
        w_state_nxt   = r_state;
        w_bub_nxt     = r_bub;
        w_wait_nxt    = r_wait;

        if (w_mw) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_flush = 1'b1;
            w_state_nxt   = S_MEM_WAIT;
            if (r_state != S_MEM_WAIT) begin
                w_wait_nxt = 8'd1;
            end else if (r_wait != 8'hFF) begin
                w_wait_nxt = r_wait + 8'd1;
            end
        end else if (ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_evt  = 1'b1;
            w_state_nxt  = S_RUN;
            w_bub_nxt    = 2'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_lu) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = S_LU_STALL;
                            w_bub_nxt   = BUB_INIT;
                        end
                    end
                end
                S_LU_STALL: begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                    w_bub_nxt    = r_bub - 2'd1;
                    if (r_bub <= 2'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_MEM_WAIT: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    assign w_timeout_set = w_mw & (w_wait_nxt >= WAIT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!w_pc_en && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_evt && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Reset forces every control low regardless of the hazard inputs.
    assign pc_en       = rst & w_pc_en;
    assign ifid_en     = rst & w_ifid_en;
    assign ifid_flush  = rst & w_ifid_flush;
    assign idex_en     = rst & w_idex_en;
    assign idex_flush  = rst & w_idex_flush;
    assign exmem_en    = rst & w_exmem_en;
    assign memwb_flush = rst & w_memwb_flush;
    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: three parameterisations share one stimulus stream;
// each cycle's expected outputs are queued by the driver and checked by a negedge monitor.
module tb_hazard_sequencer;

    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_RST = 7'b0000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_hasRs1, id_hasRs2, ex_hasRd, ex_memRead, ex_branch_taken, mem_access, dmem_ready;

    logic [6:0] ctl1, ctl2, ctl3;
    logic [1:0] st1, st2, st3;
    logic [15:0] sc1, fc1, sc2, fc2;
    logic [1:0] sc3, fc3;
    logic to1, to2, to3;

    logic [43:0] exp_q[$];
    logic [43:0] mon_e;
    logic [41:0] mon_a;
    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.LOAD_LAT(1), .MAX_WAIT(16), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_hasRs1(id_hasRs1),
        .id_hasRs2(id_hasRs2), .ex_rd(ex_rd), .ex_hasRd(ex_hasRd), .ex_memRead(ex_memRead),
        .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(ctl1[6]), .ifid_en(ctl1[5]), .ifid_flush(ctl1[4]), .idex_en(ctl1[3]),
        .idex_flush(ctl1[2]), .exmem_en(ctl1[1]), .memwb_flush(ctl1[0]), .state(st1),
        .stall_cnt(sc1), .flush_cnt(fc1), .mem_timeout(to1));

    hazard_sequencer #(.LOAD_LAT(2), .MAX_WAIT(16), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_hasRs1(id_hasRs1),
        .id_hasRs2(id_hasRs2), .ex_rd(ex_rd), .ex_hasRd(ex_hasRd), .ex_memRead(ex_memRead),
        .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(ctl2[6]), .ifid_en(ctl2[5]), .ifid_flush(ctl2[4]), .idex_en(ctl2[3]),
        .idex_flush(ctl2[2]), .exmem_en(ctl2[1]), .memwb_flush(ctl2[0]), .state(st2),
        .stall_cnt(sc2), .flush_cnt(fc2), .mem_timeout(to2));

    hazard_sequencer #(.LOAD_LAT(3), .MAX_WAIT(4), .CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_hasRs1(id_hasRs1),
        .id_hasRs2(id_hasRs2), .ex_rd(ex_rd), .ex_hasRd(ex_hasRd), .ex_memRead(ex_memRead),
        .ex_branch_taken(ex_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(ctl3[6]), .ifid_en(ctl3[5]), .ifid_flush(ctl3[4]), .idex_en(ctl3[3]),
        .idex_flush(ctl3[2]), .exmem_en(ctl3[1]), .memwb_flush(ctl3[0]), .state(st3),
        .stall_cnt(sc3), .flush_cnt(fc3), .mem_timeout(to3));

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e[43:42])
                2'd1:    mon_a = {ctl1, st1, sc1, fc1, to1};
                2'd2:    mon_a = {ctl2, st2, sc2, fc2, to2};
                default: mon_a = {ctl3, st3, 14'd0, sc3, 14'd0, fc3, to3};
            endcase
            n_vec++;
            if (mon_a !== mon_e[41:0]) begin
                n_miss++;
                $display("FAIL vec%0d dut%0d: got ctl=%b st=%0d sc=%0d fc=%0d to=%b, want ctl=%b st=%0d sc=%0d fc=%0d to=%b",
                         n_vec, mon_e[43:42], mon_a[41:35], mon_a[34:33], mon_a[32:17], mon_a[16:1], mon_a[0],
                         mon_e[41:35], mon_e[34:33], mon_e[32:17], mon_e[16:1], mon_e[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_hasRs1 = 1'b0; id_hasRs2 = 1'b0;
        ex_rd = 5'd0; ex_hasRd = 1'b0; ex_memRead = 1'b0; ex_branch_taken = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic h1,
                          input logic [4:0] rs2, input logic h2, input logic mr);
        ex_rd = rd; ex_hasRd = 1'b1; ex_memRead = mr;
        id_rs1 = rs1; id_hasRs1 = h1; id_rs2 = rs2; id_hasRs2 = h2;
    endtask

    task automatic expect_now(input logic [1:0] sel, input logic [6:0] ctl, input logic [1:0] st,
                              input int sc, input int fc, input logic to);
        exp_q.push_back({sel, ctl, st, 16'(sc), 16'(fc), to});
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b0;
        idle();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #2;
        // Reset held with a load-use hazard and a memory wait both present.
        rst = 1'b0;
        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1);
        mem_access = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            expect_now(2'd1, C_RST, 2'd0, 0, 0, 1'b0);
            expect_now(2'd2, C_RST, 2'd0, 0, 0, 1'b0);
            expect_now(2'd3, C_RST, 2'd0, 0, 0, 1'b0);
        end
        cyc(); rst = 1'b1; idle();
        expect_now(2'd1, C_DEF, 2'd0, 0, 0, 1'b0);
        expect_now(2'd2, C_DEF, 2'd0, 0, 0, 1'b0);
        expect_now(2'd3, C_DEF, 2'd0, 0, 0, 1'b0);

        // LOAD_LAT=1: lw x5 in EX, add x6,x5,x1 in ID.
        do_reset();
        cyc(); set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1); expect_now(2'd1, C_LU, 2'd0, 0, 0, 1'b0);
        cyc(); idle();                                      expect_now(2'd1, C_DEF, 2'd0, 1, 0, 1'b0);
        cyc(); set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0); expect_now(2'd1, C_DEF, 2'd0, 1, 0, 1'b0);
        cyc(); set_lu(5'd5, 5'd5, 1'b0, 5'd1, 1'b1, 1'b1); expect_now(2'd1, C_DEF, 2'd0, 1, 0, 1'b0);

        // LOAD_LAT=2 via rs2 match on x7, then the same pattern on x0.
        do_reset();
        cyc(); set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1); expect_now(2'd2, C_LU, 2'd0, 0, 0, 1'b0);
        cyc(); idle();                                      expect_now(2'd2, C_LU, 2'd1, 1, 0, 1'b0);
        cyc();                                              expect_now(2'd2, C_DEF, 2'd0, 2, 0, 1'b0);
        cyc(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1); expect_now(2'd2, C_DEF, 2'd0, 2, 0, 1'b0);
        cyc();                                              expect_now(2'd2, C_DEF, 2'd0, 2, 0, 1'b0);
        cyc(); idle();                                      expect_now(2'd2, C_DEF, 2'd0, 2, 0, 1'b0);

        // LOAD_LAT=3, CNT_W=2: branch cancels LU_STALL, branch beats lu, flush_cnt saturates.
        do_reset();
        cyc(); set_lu(5'd9, 5'd9, 1'b1, 5'd2, 1'b0, 1'b1); expect_now(2'd3, C_LU, 2'd0, 0, 0, 1'b0);
        cyc(); idle(); ex_branch_taken = 1'b1;              expect_now(2'd3, C_BR, 2'd1, 1, 0, 1'b0);
        cyc(); idle();                                      expect_now(2'd3, C_DEF, 2'd0, 1, 1, 1'b0);
        cyc(); set_lu(5'd9, 5'd9, 1'b1, 5'd2, 1'b0, 1'b1); ex_branch_taken = 1'b1;
        expect_now(2'd3, C_BR, 2'd0, 1, 1, 1'b0);
        cyc(); idle(); ex_branch_taken = 1'b1;              expect_now(2'd3, C_BR, 2'd0, 1, 2, 1'b0);
        cyc();                                              expect_now(2'd3, C_BR, 2'd0, 1, 3, 1'b0);
        cyc(); idle();                                      expect_now(2'd3, C_DEF, 2'd0, 1, 3, 1'b0);

        // Memory wait of 3 cycles, then a freeze that outranks a taken branch.
        do_reset();
        cyc(); mem_access = 1'b1; dmem_ready = 1'b0;        expect_now(2'd1, C_FRZ, 2'd0, 0, 0, 1'b0);
        cyc();                                              expect_now(2'd1, C_FRZ, 2'd2, 1, 0, 1'b0);
        cyc();                                              expect_now(2'd1, C_FRZ, 2'd2, 2, 0, 1'b0);
        cyc(); dmem_ready = 1'b1;                           expect_now(2'd1, C_DEF, 2'd2, 3, 0, 1'b0);
        cyc(); idle();                                      expect_now(2'd1, C_DEF, 2'd0, 3, 0, 1'b0);
        cyc(); mem_access = 1'b1; ex_branch_taken = 1'b1;   expect_now(2'd1, C_FRZ, 2'd0, 3, 0, 1'b0);
        cyc(); dmem_ready = 1'b1;                           expect_now(2'd1, C_BR, 2'd2, 4, 0, 1'b0);
        cyc(); idle();                                      expect_now(2'd1, C_DEF, 2'd0, 4, 1, 1'b0);

        // MAX_WAIT=4 timeout with stall_cnt saturating at 3, then async reset mid-wait.
        do_reset();
        cyc(); mem_access = 1'b1;                           expect_now(2'd3, C_FRZ, 2'd0, 0, 0, 1'b0);
        cyc();                                              expect_now(2'd3, C_FRZ, 2'd2, 1, 0, 1'b0);
        cyc();                                              expect_now(2'd3, C_FRZ, 2'd2, 2, 0, 1'b0);
        cyc();                                              expect_now(2'd3, C_FRZ, 2'd2, 3, 0, 1'b0);
        cyc();                                              expect_now(2'd3, C_FRZ, 2'd2, 3, 0, 1'b1);
        cyc();                                              expect_now(2'd3, C_FRZ, 2'd2, 3, 0, 1'b1);
        cyc(); rst = 1'b0;
        expect_now(2'd3, C_RST, 2'd0, 0, 0, 1'b0);
        expect_now(2'd1, C_RST, 2'd0, 0, 0, 1'b0);
        cyc(); rst = 1'b1; idle();
        expect_now(2'd3, C_DEF, 2'd0, 0, 0, 1'b0);
        expect_now(2'd1, C_DEF, 2'd0, 0, 0, 1'b0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            cyc();
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Sequences the stall/flush/enable controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC in the 5-stage RISC-V core.
- Detects load-use hazards between ID and EX, squashes wrong-path instructions on a taken branch resolved in EX, and freezes the pipe while a data-memory access waits for dmem_ready.
- Keeps saturating stall and flush counters and a sticky memory-timeout flag.

Parameters:
LOAD_LAT, 1, bubbles inserted per load-use hazard (1 with MEM->EX forwarding, 2 without); legal 1..3
MAX_WAIT, 16, MEM_WAIT cycles before mem_timeout sets; legal 2..255
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_hasRs1  in  1  ID instruction reads rs1
id_hasRs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd index of instruction in EX
ex_hasRd  in  1  EX instruction writes rd
ex_memRead  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump in EX redirects PC this cycle
mem_access  in  1  EX/MEM instruction has memRead or memWrite
dmem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID load bubble
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX load bubble (all control bits 0)
exmem_en  out  1  EX/MEM load enable
memwb_flush  out  1  MEM/WB load bubble
state  out  2  0=RUN 1=LU_STALL 2=MEM_WAIT
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating
mem_timeout  out  1  sticky: MEM_WAIT reached MAX_WAIT cycles

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- While rst=0: state=RUN, counters 0, mem_timeout 0. All *_en outputs 0 and all *_flush outputs 0, forced regardless of inputs.
- Reset asserted mid-operation aborts any stall/wait immediately. First edge after release runs RUN logic.
- Hazard term: lu = ex_memRead & ex_hasRd & (ex_rd!=0) & ((id_hasRs1 & id_rs1==ex_rd) | (id_hasRs2 & id_rs2==ex_rd)).
- Wait term: mw = mem_access & !dmem_ready.
- Outputs are Mealy (state + current inputs). Defaults: all en=1, all flush=0.
- Priority each cycle: mw > ex_branch_taken > lu / LU_STALL.
- mw in any state (freeze):
  - pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1.
  - Next state MEM_WAIT.
  - Wait counter increments; it is cleared on entry from another state.
- MEM_WAIT with dmem_ready=1: normal advance (defaults). Next state RUN.
- Timeout: wait counter reaching MAX_WAIT sets mem_timeout. The block stays in MEM_WAIT; no abort.
- ex_branch_taken with no mw:
  - ifid_flush=1, idex_flush=1, other enables 1.
  - flush_cnt+1.
  - Next state RUN. This also cancels a pending LU_STALL.
- RUN, lu, no branch, no mw:
  - pc_en=0, ifid_en=0, idex_flush=1.
  - If LOAD_LAT>1: next state LU_STALL, bubble counter = LOAD_LAT-1; else stay RUN.
- LU_STALL, no branch, no mw:
  - Same outputs as the lu case in RUN; bubble counter decrements.
  - When it reaches 0: next state RUN.
  - lu is not re-evaluated inside LU_STALL.
- stall_cnt: +1 every cycle pc_en=0 with rst=1; saturates at all-ones. flush_cnt saturates likewise.
- x0 never causes a hazard.
- Simultaneous lu and branch: branch wins; no stall cycle is counted.

Test Plan:
- Reset: hold rst=0 with mw=1 and lu=1 asserted -> all enables/flushes 0, state=0, counters 0. Release -> RUN defaults.
- Load-use, LOAD_LAT=1: ex lw x5, id add x6,x5,x1 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1. Then defaults; stall_cnt=1.
- Load-use, LOAD_LAT=2, ex_rd=0 case: rd=x7 gives 2 bubble cycles with state 0->1->0, stall_cnt=2. Same sequence with ex_rd=0 gives no stall.
- Branch during LU_STALL (LOAD_LAT=3): ex_branch_taken in the first LU_STALL cycle -> ifid_flush=idex_flush=1, state=RUN next cycle, flush_cnt=1.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> 3 freeze cycles with memwb_flush=1, state=2. Then an advance cycle and state=0; stall_cnt=3, mem_timeout=0.
- Timeout and mid-wait reset: MAX_WAIT=4, dmem_ready held 0 for 6 cycles -> mem_timeout=1 after the 4th wait cycle and stays set. Asserting rst mid-wait -> state=0, mem_timeout=0 immediately (asynchronous).
